// File: rtl/acc_reg_stack.sv
// Purpose : WIDTH-bit bus accumulator with ALU-style ops and a DEPTH-entry save/restore stack.
// Latency : one falling edge of Clk from strobe (ACC_IN/PUSH/POP) to updated acc/flags.
// Backpr. : none; every strobe is acted on the edge it is sampled, illegal stack ops set STK_ERR.
//
// Ports:
//   Clk, Rst            clock (state updates on falling edge), synchronous active-high reset
//   ACC_IN, OP          operation strobe and 3-bit operation select
//   ACC_VAL_IN          operand from the data bus
//   ACC_OUT             bus drive enable; ACC_VAL_OUT is high-Z when low
//   ACC_VAL_OUT         accumulator onto the shared bus
//   PUSH, POP           save / restore accumulator on the internal stack
//   ZF, CF              zero flag (combinational) and carry/borrow/shift-out flag (registered)
//   STK_FULL/EMPTY/ERR  stack status; STK_ERR is sticky until Rst
//
// Build option: define ACC_SAT_EN to make add/sub saturate instead of wrapping.

module acc_reg_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ACC_IN,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] ACC_VAL_IN,
  input  logic             ACC_OUT,
  output logic [WIDTH-1:0] ACC_VAL_OUT,
  input  logic             PUSH,
  input  logic             POP,
  output logic             ZF,
  output logic             CF,
  output logic             STK_FULL,
  output logic             STK_EMPTY,
  output logic             STK_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             cf_q;
  logic             cf_nxt;
  logic             err_q;
  logic [AW:0]      sp;
  logic [AW:0]      sp_dec;
  logic [WIDTH-1:0] mem [DEPTH];

  // One extra MSB on each path captures carry (add) or borrow (sub).
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  logic push_ok;
  logic pop_ok;
  logic err_evt;

  assign sum    = {1'b0, acc} + {1'b0, ACC_VAL_IN};
  assign diff   = {1'b0, acc} - {1'b0, ACC_VAL_IN};
  assign sp_dec = sp - SP_ONE;

  // ALU result; only committed when ACC_IN is high and no POP takes over.
  always_comb begin
    acc_nxt = acc;
    cf_nxt  = cf_q;
    case (OP)
      OP_HOLD:  acc_nxt = acc;
      OP_LOAD:  acc_nxt = ACC_VAL_IN;
      OP_ADD: begin
        cf_nxt = sum[WIDTH];
`ifdef ACC_SAT_EN
        acc_nxt = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        acc_nxt = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        cf_nxt = diff[WIDTH];
`ifdef ACC_SAT_EN
        acc_nxt = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
        acc_nxt = diff[WIDTH-1:0];
`endif
      end
      OP_SHL: begin
        acc_nxt = {acc[WIDTH-2:0], 1'b0};
        cf_nxt  = acc[WIDTH-1];
      end
      OP_SHR: begin
        acc_nxt = {1'b0, acc[WIDTH-1:1]};
        cf_nxt  = acc[0];
      end
      OP_AND:   acc_nxt = acc & ACC_VAL_IN;
      OP_CLEAR: acc_nxt = {WIDTH{1'b0}};
      default:  acc_nxt = acc;
    endcase
  end

  assign STK_FULL  = (sp == SP_FULL);
  assign STK_EMPTY = (sp == '0);

  // PUSH and POP together cancel each other and count as an error.
  assign push_ok = PUSH & ~POP & ~STK_FULL;
  assign pop_ok  = POP & ~PUSH & ~STK_EMPTY;
  assign err_evt = (PUSH & POP) | (PUSH & ~POP & STK_FULL) | (POP & ~PUSH & STK_EMPTY);

  always_ff @(negedge Clk) begin
    if (Rst) begin
      acc   <= '0;
      cf_q  <= 1'b0;
      sp    <= '0;
      err_q <= 1'b0;
    end else begin
      // A successful POP restores acc and leaves CF alone, overriding ACC_IN.
      if (pop_ok) begin
        acc <= mem[sp_dec[AW-1:0]];
      end else if (ACC_IN) begin
        acc  <= acc_nxt;
        cf_q <= cf_nxt;
      end

      if (push_ok) begin
        sp <= sp + SP_ONE;
      end else if (pop_ok) begin
        sp <= sp_dec;
      end

      if (err_evt) begin
        err_q <= 1'b1;
      end
    end
  end

  // Stack storage has no reset; the pre-operation acc is what gets saved.
  always_ff @(negedge Clk) begin
    if (!Rst && push_ok) begin
      mem[sp[AW-1:0]] <= acc;
    end
  end

  assign ACC_VAL_OUT = ACC_OUT ? acc : {WIDTH{1'bz}};
  assign ZF          = (acc == '0);
  assign CF          = cf_q;
  assign STK_ERR     = err_q;

endmodule

// File: doc/acc_reg_stack.md
Name: acc_reg_stack

Overview:
- Parametrised successor to the 4-bit bus accumulator.
- Holds a WIDTH-bit accumulator that performs load and ALU-style update operations from the data bus.
- Drives the shared tri-state data bus on request.
- Provides a DEPTH-entry save/restore stack so the control unit can push and pop the accumulator around subroutines.
- Sits between the control sequencer and the shared data bus.

Parameters:
- WIDTH, 4, accumulator and bus width in bits (>=2).
- DEPTH, 4, number of save-stack entries (power of 2, >=2).

Ports:
- Clk  input  1  system clock; all state updates on falling edge.
- Rst  input  1  synchronous active-high reset.
- ACC_IN  input  1  operation strobe; OP is executed when high.
- OP  input  3  operation select, valid when ACC_IN=1.
- ACC_VAL_IN  input  WIDTH  operand from data bus.
- ACC_OUT  input  1  bus drive enable.
- ACC_VAL_OUT  output  WIDTH  accumulator onto bus; high-Z when ACC_OUT=0.
- PUSH  input  1  save accumulator to stack.
- POP  input  1  restore accumulator from stack.
- ZF  output  1  accumulator == 0.
- CF  output  1  carry/borrow/shifted-out bit of last arithmetic or shift op.
- STK_FULL  output  1  stack holds DEPTH entries.
- STK_EMPTY  output  1  stack holds 0 entries.
- STK_ERR  output  1  sticky: push when full or pop when empty.

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-high on Rst, sampled at the falling edge of Clk. All registered state updates on the falling edge.
- Reset values: acc=0, CF=0, stack pointer=0, STK_ERR=0. Hence ZF=1, STK_EMPTY=1, STK_FULL=0. Stack contents are don't-care. Rst overrides every other input in the same edge. Reset mid-push or mid-op discards that operation.
- OP encoding, applied when ACC_IN=1:
  - 000 hold
  - 001 load acc=ACC_VAL_IN
  - 010 add acc=acc+ACC_VAL_IN, CF=carry out
  - 011 sub acc=acc-ACC_VAL_IN, CF=borrow (1 when ACC_VAL_IN>acc unsigned)
  - 100 shl acc={acc[W-2:0],0}, CF=acc[W-1]
  - 101 shr acc={0,acc[W-1:1]}, CF=acc[0]
  - 110 and acc=acc&ACC_VAL_IN
  - 111 clear acc=0
- CF changes only on ops 010-101; it holds otherwise.
- Arithmetic is unsigned modulo 2^WIDTH and wraps unless ACC_SAT_EN is defined.
- Latency: result is visible on the acc register one falling edge after the strobe.
- ACC_VAL_OUT is combinational from ACC_OUT and the current acc. It is therefore updated in the same cycle the register changes, with no stale value.
- ZF is combinational from acc.
- Stack:
  - PUSH: mem[sp]=acc, sp++.
  - POP: acc=mem[sp-1], sp--. POP overrides any ACC_IN operation in the same edge; CF holds.
  - PUSH together with ACC_IN: the pre-operation acc is pushed and the operation still executes.
  - PUSH and POP together: both are ignored and treated as an error (STK_ERR=1); acc and sp are unchanged, but ACC_IN still executes.
  - PUSH when full: ignored and STK_ERR=1.
  - POP when empty: ignored and STK_ERR=1; acc is unchanged and ACC_IN still executes.
  - STK_ERR clears only on Rst.
- STK_FULL is (sp==DEPTH) and STK_EMPTY is (sp==0). The sp register is clog2(DEPTH)+1 bits wide.
- No internal bus arbitration. Contention between ACC_OUT and other drivers is the control unit's responsibility.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - add clamps to all-ones on carry.
  - sub clamps to 0 on borrow.
  - CF still reports the overflow/borrow condition.
  - Shifts and the other ops are unchanged.
- Undefined: add and sub wrap modulo 2^WIDTH. No saturation logic is instantiated.

Test Plan:
- WIDTH=4: Rst=1 for one edge, then ACC_OUT=1 -> ACC_VAL_OUT=0000, ZF=1, STK_EMPTY=1, STK_ERR=0. With ACC_OUT=0 -> bus is zzzz.
- Load 4'hA, then add 4'h7 -> acc=4'h1 and CF=1 (wrap). With ACC_SAT_EN defined -> acc=4'hF and CF=1.
- acc=3, then sub 5 -> acc=4'hE and CF=1 (0 with ACC_SAT_EN). Then shl -> acc=4'hC and CF=1. Then shr -> acc=4'h6 and CF=0.
- DEPTH=4: push 1,2,3,4 -> STK_FULL=1. A fifth push -> ignored and STK_ERR=1. Pop four times -> acc sequence 4,3,2,1 and STK_EMPTY=1. A fifth pop -> acc stays 1.
- Same edge with acc=5, PUSH=1, ACC_IN=1, OP=001, ACC_VAL_IN=9 -> acc=9 and top of stack=5. Then POP together with ACC_IN load 2 -> acc=5 (pop wins).
- Assert Rst together with ACC_IN add and PUSH -> acc=0, sp=0, STK_ERR=0 on that edge, and no stack write.
